semaforo_sequencer: RTL

Local phase sequencer for the four-approach intersection. It produces the 4-bit `ciclo` code and `destello` flag that drive the traffic-light decoder. In automatic mode it steps green → amber through approaches 1–4 with configurable timings. In external mode it forwards the ESP32 command, guarded by a heartbeat watchdog, and falls back to flashing amber on loss of the ESP32 or on any mode change.

---
 rtl/semaforo_pkg.sv | 28 ++
 rtl/semaforo_sequencer_tick_gen.sv | 38 +++
 rtl/semaforo_sequencer.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/semaforo_pkg.sv
// Shared types, phase-code constants and helpers for the intersection phase sequencer.
package semaforo_pkg;

  typedef enum logic [1:0] {
    StFlash,
    StGreen,
    StAmber,
    StExt
  } state_t;

  typedef enum logic [1:0] {
    ModeFlash = 2'd0,
    ModeAuto  = 2'd1,
    ModeExt   = 2'd2
  } mode_t;

  localparam logic [3:0] CICLO_FLASH = 4'd0;
  localparam logic [3:0] CICLO_MAX   = 4'd8;

  function automatic logic [3:0] green_code(input logic [1:0] n);
    return {1'b0, n, 1'b1};
  endfunction

  function automatic logic [3:0] amber_code(input logic [1:0] n);
    return {1'b0, n, 1'b0} + 4'd2;
  endfunction

endpackage

// File: rtl/semaforo_sequencer_tick_gen.sv
// Prescaler: half-second strobe, 1 Hz blink square wave and a once-per-second strobe.
module tick_gen #(
  parameter int unsigned CLK_HZ = 27_000_000
) (
  input  logic clk,
  input  logic rst,
  output logic half_tick,
  output logic sec_tick,
  output logic blink
);

  localparam int unsigned Half = CLK_HZ / 2;
  localparam int unsigned CntW = (Half > 1) ? $clog2(Half) : 1;

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            blink_q, blink_d;

  assign half_tick = (cnt_q == CntW'(Half - 1));
  // Second boundary lands on the falling edge of blink.
  assign sec_tick  = half_tick & blink_q;
  assign blink     = blink_q;

  always_comb begin
    cnt_d   = half_tick ? '0 : cnt_q + 1'b1;
    blink_d = blink_q ^ half_tick;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      blink_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      blink_q <= blink_d;
    end
  end

endmodule

// File: rtl/semaforo_sequencer.sv
// Four-approach phase sequencer: local green/amber cycling or ESP32 pass-through with a
// heartbeat watchdog, falling back to flashing amber between modes.
module semaforo_sequencer
  import semaforo_pkg::*;
#(
  parameter int unsigned CLK_HZ  = 27_000_000,
  parameter int unsigned GREEN_S = 20,
  parameter int unsigned BLINK_S = 3,
  parameter int unsigned AMBER_S = 3,
  parameter int unsigned FLASH_S = 5,
  parameter int unsigned WDT_S   = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       auto_en,
  input  logic [3:0] esp_ciclo,
  input  logic       esp_dest,
  input  logic       esp_alive,
  output logic [3:0] ciclo,
  output logic       destello,
  output logic       blink,
  output logic [1:0] mode,
  output logic       wdt_fault
);

  localparam int unsigned MaxGf = (GREEN_S > FLASH_S) ? GREEN_S : FLASH_S;
  localparam int unsigned MaxS  = (MaxGf > AMBER_S) ? MaxGf : AMBER_S;
  localparam int unsigned SecW  = $clog2(MaxS + 1);
  localparam int unsigned WdtW  = (WDT_S > 1) ? $clog2(WDT_S) : 1;

  localparam logic [SecW-1:0] FlashLast  = SecW'(FLASH_S - 1);
  localparam logic [SecW-1:0] GreenLast  = SecW'(GREEN_S - 1);
  localparam logic [SecW-1:0] AmberLast  = SecW'(AMBER_S - 1);
  localparam logic [SecW-1:0] GreenBlink = SecW'(GREEN_S - BLINK_S);
  localparam logic [WdtW-1:0] WdtLast    = WdtW'(WDT_S - 1);

  // {auto_en, esp_dest, esp_alive, esp_ciclo}
  logic [6:0] sync1_q, sync2_q;
  logic       auto_s, dest_s, alive_s;
  logic [3:0] ciclo_s;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= {auto_en, esp_dest, esp_alive, esp_ciclo};
      sync2_q <= sync1_q;
    end
  end

  assign auto_s  = sync2_q[6];
  assign dest_s  = sync2_q[5];
  assign alive_s = sync2_q[4];
  assign ciclo_s = sync2_q[3:0];

  logic half_tick, sec_tick, blink_nx;

  tick_gen #(
    .CLK_HZ(CLK_HZ)
  ) u_tick_gen (
    .clk      (clk),
    .rst      (rst),
    .half_tick(half_tick),
    .sec_tick (sec_tick),
    .blink    (blink)
  );

  // Blink value visible alongside the registered outputs.
  assign blink_nx = blink ^ half_tick;

  logic            alive_prev_q, alive_edge;
  logic [WdtW-1:0] wdt_cnt_q, wdt_cnt_d;
  logic            wdt_fault_q, wdt_fault_d;

  assign alive_edge = alive_s ^ alive_prev_q;

  always_comb begin
    wdt_cnt_d   = wdt_cnt_q;
    wdt_fault_d = wdt_fault_q;
    if (alive_edge) begin
      wdt_cnt_d   = '0;
      wdt_fault_d = 1'b0;
    end else if (sec_tick && !wdt_fault_q) begin
      if (wdt_cnt_q == WdtLast) wdt_fault_d = 1'b1;
      else                      wdt_cnt_d   = wdt_cnt_q + 1'b1;
    end
  end

  state_t          state_q, state_d;
  logic [1:0]      appr_q, appr_d;
  logic [SecW-1:0] sec_q, sec_d;
  logic [3:0]      ciclo_q, ciclo_d;
  logic            dest_q, dest_d;
  mode_t           mode_q, mode_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      alive_prev_q <= 1'b0;
      wdt_cnt_q    <= '0;
      wdt_fault_q  <= 1'b0;
      state_q      <= StFlash;
      appr_q       <= 2'd0;
      sec_q        <= '0;
      ciclo_q      <= CICLO_FLASH;
      dest_q       <= 1'b0;
      mode_q       <= ModeFlash;
    end else begin
      alive_prev_q <= alive_s;
      wdt_cnt_q    <= wdt_cnt_d;
      wdt_fault_q  <= wdt_fault_d;
      state_q      <= state_d;
      appr_q       <= appr_d;
      sec_q        <= sec_d;
      ciclo_q      <= ciclo_d;
      dest_q       <= dest_d;
      mode_q       <= mode_d;
    end
  end

  always_comb begin
    state_d = state_q;
    appr_d  = appr_q;
    sec_d   = sec_tick ? sec_q + 1'b1 : sec_q;
    unique case (state_q)
      StFlash: begin
        if (sec_tick && sec_q == FlashLast) begin
          sec_d = '0;
          if (auto_s) begin
            state_d = StGreen;
            appr_d  = 2'd0;
          end else if (!wdt_fault_d) begin
            state_d = StExt;
          end
        end
      end
      StGreen: begin
        if (sec_tick && sec_q == GreenLast) begin
          sec_d   = '0;
          state_d = StAmber;
        end
      end
      StAmber: begin
        if (sec_tick && sec_q == AmberLast) begin
          sec_d = '0;
          if (auto_s) begin
            state_d = StGreen;
            appr_d  = appr_q + 2'd1;
          end else begin
            state_d = StFlash;
          end
        end
      end
      StExt: begin
        sec_d = '0;
        // wdt_fault is always clear while in EXT, so a set here is its rising edge.
        if (wdt_fault_d || auto_s) state_d = StFlash;
      end
    endcase
  end

  always_comb begin
    ciclo_d = CICLO_FLASH;
    dest_d  = 1'b0;
    mode_d  = ModeFlash;
    unique case (state_d)
      StFlash: dest_d = blink_nx;
      StGreen: begin
        ciclo_d = green_code(appr_d);
        dest_d  = blink_nx & (sec_d >= GreenBlink);
        mode_d  = ModeAuto;
      end
      StAmber: begin
        ciclo_d = amber_code(appr_d);
        mode_d  = ModeAuto;
      end
      StExt: begin
        ciclo_d = (ciclo_s <= CICLO_MAX) ? ciclo_s : CICLO_FLASH;
        dest_d  = dest_s & blink_nx;
        mode_d  = ModeExt;
      end
    endcase
  end

  assign ciclo     = ciclo_q;
  assign destello  = dest_q;
  assign mode      = mode_q;
  assign wdt_fault = wdt_fault_q;

endmodule
